mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Load/store initiator between the pipeline MEM stage and the word-only data memory.
//  Accepts byte/half/word loads and stores via a valid/ready handshake.
//  Sub-word stores become read-modify-write sequences; load data is lane-extracted and extended.
//  Drives the memory's word address, write data, write enable and PC trace port.
// PARAMETERS
//  ADDR_LIMIT  32'h0000_1000  first invalid byte address; req_addr >= ADDR_LIMIT -> error response
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   asynchronous, active-high
//  req_valid   in   1   request present
//  req_ready   out  1   controller idle; request accepted on req_valid&&req_ready at posedge
//  req_we      in   1   1=store, 0=load
//  req_size    in   2   0=byte, 1=half, 2=word, 3=reserved (treated as error)
//  req_sign    in   1   loads: 1=sign-extend, 0=zero-extend
//  req_addr    in   32  byte address
//  req_wdata   in   32  store data, right-justified
//  req_pc      in   32  PC of issuing instruction
//  resp_valid  out  1   one-cycle completion pulse
//  resp_rdata  out  32  extended load data; 0 for stores and errors
//  resp_err    out  1   valid with resp_valid; 1 = misaligned/out-of-range/reserved size
//  mem_addr    out  32  word-aligned address {addr[31:2],2'b00}
//  mem_wdata   out  32  full word to write
//  mem_we      out  1   memory write enable, writes on posedge
//  mem_pc      out  32  latched req_pc, for memory trace
//  mem_rdata   in   32  combinational memory read data for mem_addr
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_we=0;
//    mem_addr/mem_wdata/mem_pc=0. Async reset mid-sequence aborts the op; no partial write
//    (mem_we decoded from state, drops immediately).
//  - States: IDLE, RD, WR, RESP. On accept: latch we/size/sign/addr/wdata/pc.
//    IDLE->RESP if error; load->RD; word store->WR; byte/half store->RD.
//    RD: mem_we=0, capture mem_rdata into rbuf at edge; load->RESP, store->WR.
//    WR: mem_we=1, mem_wdata=merged word; ->RESP.
//    RESP: resp_valid=1 one cycle; ->IDLE (req_ready=1 the following cycle).
//  - Latency, accept edge to resp_valid high: load 2 cycles; word store 2; sub-word store 3;
//    error 1. No back-to-back accept; req_valid while busy is ignored.
//  - Lanes little-endian: byte k=addr[1:0] occupies bits [8k+7:8k]; half uses addr[1]
//    (bits [15:0] or [31:16]). Merge replaces only the addressed lane of rbuf with the low
//    bits of wdata; other lanes are preserved bit-exact.
//  - Load extract: lane shifted to bit 0, extended to 32 bits per latched sign.
//  - Range check on full 32-bit addr, unsigned; an error never drives mem_we.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 -> error
//    response, no memory access.
//  MEM_ALIGN_CHECK_EN undefined: low address bits forced to alignment (half clears bit0,
//    word clears [1:0]) and the op proceeds; resp_err only for range or reserved size.
// TESTING
//  1 Reset: assert reset mid-WR -> mem_we falls same cycle; memory word unchanged; IDLE, ready=1.
//  2 Word store 0x10 data 0xDEADBEEF -> mem_we one cycle, addr 0x10; load word 0x10 returns
//    0xDEADBEEF, resp 2 cycles after accept.
//  3 Word 0x10 = 0x11223344; store byte 0x13 data 0xAA -> word 0xAA223344;
//    store half 0x10 data 0x5566 -> 0xAA225566; both resp 3 cycles after accept.
//  4 Word 0x20 = 0x0000_80F0: lb signed 0x20 -> 0xFFFFFFF0; lbu 0x20 -> 0x000000F0;
//    lh signed 0x20 -> 0xFFFF80F0; lhu 0x22 -> 0x00000000.
//  5 With MEM_ALIGN_CHECK_EN: sw 0x12 -> resp_err=1 one cycle after accept, mem_we never high;
//    without it: sw 0x12 writes word 0x10.
//  6 Load 0x1000 (=ADDR_LIMIT) or req_size=3 -> resp_err=1, resp_rdata=0; req_valid held
//    during busy is accepted exactly once per IDLE.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl_if
//  Description : Bundle of the MEM-stage request/response handshake and the
//                word-only data-memory port seen by mem_access_ctrl.
//                slave  : controller view (takes requests, drives memory)
//                master : pipeline + memory view (issues requests, serves reads)
//  Signals     : req_valid/req_ready/req_we/req_size/req_sign/req_addr/
//                req_wdata/req_pc, resp_valid/resp_rdata/resp_err,
//                mem_addr/mem_wdata/mem_we/mem_pc/mem_rdata
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_pc;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_we, mem_pc
    );

    modport master (
        output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_we, mem_pc
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : Load/store initiator between the MEM stage and a word-only
//                data memory. Byte/half stores are done as read-modify-write;
//                loads are lane-extracted and sign/zero extended.
//  Ports       : clk    - rising-edge clock
//                reset  - asynchronous, active-high
//                bus    - mem_access_ctrl_if.slave (request, response and
//                         memory port signals)
//  Parameters  : ADDR_LIMIT - first invalid byte address (error at or above)
//  Options     : MEM_ALIGN_CHECK_EN - misaligned half/word -> error response;
//                undefined: low address bits are forced to alignment.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_access_ctrl #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mem_access_ctrl_if.slave   bus
);

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rbuf_q, rbuf_d;

    // Request decode: error classification and effective (aligned) address
    logic        req_err;
    logic [31:0] req_addr_eff;

    always_comb begin
        req_err      = (bus.req_size == SZ_RSVD) || (bus.req_addr >= ADDR_LIMIT);
        req_addr_eff = bus.req_addr;
`ifdef MEM_ALIGN_CHECK_EN
        if ((bus.req_size == SZ_HALF && bus.req_addr[0]) ||
            (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)) begin
            req_err = 1'b1;
        end
`else
        if (bus.req_size == SZ_HALF) begin
            req_addr_eff[0] = 1'b0;
        end else if (bus.req_size == SZ_WORD) begin
            req_addr_eff[1:0] = 2'b00;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            pc_q    <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            pc_q    <= pc_d;
            rbuf_q  <= rbuf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        sign_d  = sign_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    sign_d  = bus.req_sign;
                    err_d   = req_err;
                    addr_d  = req_addr_eff;
                    wdata_d = bus.req_wdata;
                    pc_d    = bus.req_pc;
                    if (req_err)
                        state_d = ST_RESP;
                    else if (bus.req_we && bus.req_size == SZ_WORD)
                        state_d = ST_WR;
                    else
                        state_d = ST_RD;
                end
            end
            ST_RD: begin
                rbuf_d  = bus.mem_rdata;
                state_d = we_q ? ST_WR : ST_RESP;
            end
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Lane handling: byte lane k sits at bits [8k+7:8k], half lane at [16h+15:16h]
    logic [4:0]  lane_shift;
    logic [31:0] merged;
    logic [31:0] lane_data;
    logic [31:0] load_ext;

    always_comb begin
        lane_shift = {addr_q[1:0], 3'b000};
        merged     = rbuf_q;
        case (size_q)
            SZ_BYTE: merged[lane_shift +: 8]  = wdata_q[7:0];
            SZ_HALF: merged[lane_shift +: 16] = wdata_q[15:0];
            default: merged = wdata_q;
        endcase

        lane_data = rbuf_q >> lane_shift;
        case (size_q)
            SZ_BYTE: load_ext = {{24{sign_q & lane_data[7]}},  lane_data[7:0]};
            SZ_HALF: load_ext = {{16{sign_q & lane_data[15]}}, lane_data[15:0]};
            default: load_ext = rbuf_q;
        endcase
    end

    // Outputs decoded from state so reset removes mem_we immediately
    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_err   = (state_q == ST_RESP) && err_q;
    assign bus.resp_rdata = (state_q == ST_RESP && !we_q && !err_q) ? load_ext : 32'h0;
    assign bus.mem_we     = (state_q == ST_WR);
    assign bus.mem_addr   = {addr_q[31:2], 2'b00};
    assign bus.mem_wdata  = merged;
    assign bus.mem_pc     = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_ctrl
//  Description : Self-checking bench for mem_access_ctrl: directed scenarios
//                followed by random loads/stores against a word-array model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_access_ctrl;

    localparam logic [31:0] C_LIMIT = 32'h0000_1000;

    logic clk;
    logic reset;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.ADDR_LIMIT(C_LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory attached to the DUT, plus an independent reference copy
    logic [31:0] dut_mem [0:1023];
    logic [31:0] ref_mem [0:1023];
    logic        init_en;
    logic [9:0]  init_idx;
    logic [31:0] init_val;

    always @(posedge clk) begin
        if (init_en)
            dut_mem[init_idx] <= init_val;
        else if (bus.mem_we === 1'b1)
            dut_mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = dut_mem[bus.mem_addr[11:2]];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          we_cnt   = 0;
    int          acc_cnt  = 0;
    logic [31:0] last_we_addr = '0;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            we_cnt++;
            last_we_addr = bus.mem_addr;
        end
    end

    always @(posedge clk) begin
        if (!reset && bus.req_valid === 1'b1 && bus.req_ready === 1'b1)
            acc_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // One transaction with the model computed from the lane/extension rules
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic sign, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] pc);
        logic        exp_err;
        logic [31:0] ea, w, v, mask, exp_rdata, old_word, new_word;
        int          exp_lat, sh, lat, guard, acc0, we0;
        logic        got_err;
        logic [31:0] got_rdata;

        exp_err = (size == 2'd3) || (addr >= C_LIMIT);
        ea = addr;
`ifdef MEM_ALIGN_CHECK_EN
        if ((size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00))
            exp_err = 1'b1;
`else
        if (size == 2'd1) ea = addr & ~32'd1;
        if (size == 2'd2) ea = addr & ~32'd3;
`endif
        sh   = (ea % 4) * 8;
        w    = ref_mem[ea[11:2]];
        mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        v    = (w >> sh) & mask;
        if (sign && size == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
        if (sign && size == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
        exp_rdata = (exp_err || we) ? 32'h0 : v;
        if (exp_err)                exp_lat = 1;
        else if (!we || size == 2) exp_lat = 2;
        else                        exp_lat = 3;
        new_word = (w & ~(mask << sh)) | ((wdata << sh) & (mask << sh));

        guard = 0;
        while (bus.req_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_ready"}, {31'b0, bus.req_ready}, 32'd1);

        acc0 = acc_cnt;
        we0  = we_cnt;
        old_word = dut_mem[ea[11:2]];
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_sign  = sign;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_pc    = pc;

        @(posedge clk); #1;
        lat = 1;
        check({tag, "_pc"}, bus.mem_pc, pc);
        // Scramble request fields; the controller must work from latched copies
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_size  = 2'($urandom_range(0, 3));
        bus.req_sign  = 1'($urandom_range(0, 1));
        while (bus.resp_valid !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        got_err   = bus.resp_err;
        got_rdata = bus.resp_rdata;
        bus.req_valid = 1'b0;

        check({tag, "_lat"},   32'(lat), 32'(exp_lat));
        check({tag, "_err"},   {31'b0, got_err}, {31'b0, exp_err});
        check({tag, "_rdata"}, got_rdata, exp_rdata);
        check({tag, "_accepts"}, 32'(acc_cnt - acc0), 32'd1);

        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'b0, bus.resp_valid}, 32'd0);
        check({tag, "_we_cnt"}, 32'(we_cnt - we0), (we && !exp_err) ? 32'd1 : 32'd0);
        if (we && !exp_err) begin
            ref_mem[ea[11:2]] = new_word;
            check({tag, "_we_addr"}, last_we_addr, {ea[31:2], 2'b00});
            check({tag, "_memword"}, dut_mem[ea[11:2]], new_word);
        end else if (ea < C_LIMIT) begin
            check({tag, "_memkeep"}, dut_mem[ea[11:2]], old_word);
        end
    endtask

    task automatic rand_op(input int n);
        logic [31:0] a;
        logic [1:0]  s;
        int          r;
        r = $urandom_range(0, 9);
        if (r < 7)       a = $urandom_range(0, 63);
        else if (r == 7) a = $urandom_range(32'hFF8, 32'h1007);
        else if (r == 8) a = $urandom;
        else             a = $urandom_range(0, 4095);
        s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        do_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), s,
               1'($urandom_range(0, 1)), a, $urandom, $urandom);
    endtask

    initial begin
        logic [31:0] old;
        reset         = 1'b1;
        init_en       = 1'b1;
        init_idx      = '0;
        init_val      = '0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'd0;
        bus.req_sign  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_pc    = '0;

        for (int i = 0; i < 1024; i++) begin
            init_idx   = 10'(i);
            init_val   = $urandom;
            ref_mem[i] = init_val;
            @(posedge clk); #1;
        end
        init_en = 1'b0;

        check("rst_ready",  {31'b0, bus.req_ready},  32'd1);
        check("rst_rvalid", {31'b0, bus.resp_valid}, 32'd0);
        check("rst_rerr",   {31'b0, bus.resp_err},   32'd0);
        check("rst_rdata",  bus.resp_rdata, 32'd0);
        check("rst_mem_we", {31'b0, bus.mem_we},     32'd0);
        check("rst_maddr",  bus.mem_addr,  32'd0);
        check("rst_mwdata", bus.mem_wdata, 32'd0);
        check("rst_mpc",    bus.mem_pc,    32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Word store then load back
        do_req("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h100);
        do_req("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h104);

        // Sub-word read-modify-write
        do_req("sw10b", 1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 32'h108);
        do_req("sb13",  1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00AA, 32'h10C);
        check("sb13_word", dut_mem[4], 32'hAA22_3344);
        do_req("sh10",  1'b1, 2'd1, 1'b0, 32'h10, 32'h0000_5566, 32'h110);
        check("sh10_word", dut_mem[4], 32'hAA22_5566);

        // Extension cases
        do_req("sw20", 1'b1, 2'd2, 1'b0, 32'h20, 32'h0000_80F0, 32'h114);
        do_req("lb20",  1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 32'h118);
        do_req("lbu20", 1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 32'h11C);
        do_req("lh20",  1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 32'h120);
        do_req("lhu22", 1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'h124);

        // Misaligned word store, range and reserved-size errors
        do_req("sw12",   1'b1, 2'd2, 1'b0, 32'h12, 32'h0BAD_F00D, 32'h128);
        do_req("lw1000", 1'b0, 2'd2, 1'b0, C_LIMIT, 32'h0, 32'h12C);
        do_req("lsz3",   1'b0, 2'd3, 1'b1, 32'h30, 32'h0, 32'h130);

        // Reset in the write cycle of a byte store
        old = dut_mem[17];
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'd0;
        bus.req_sign  = 1'b0;
        bus.req_addr  = 32'h45;
        bus.req_wdata = ~old;
        bus.req_pc    = 32'h200;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("rwr_we_hi", {31'b0, bus.mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("rwr_we_lo",  {31'b0, bus.mem_we},     32'd0);
        check("rwr_ready",  {31'b0, bus.req_ready},  32'd1);
        check("rwr_rvalid", {31'b0, bus.resp_valid}, 32'd0);
        @(posedge clk); #1;
        check("rwr_mem", dut_mem[17], old);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 300; n++)
            rand_op(n);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
